// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and defaults for the calculator datapath
package calc_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  localparam logic [1:0] ST_A   = 2'd0;
  localparam logic [1:0] ST_B   = 2'd1;
  localparam logic [1:0] ST_OP  = 2'd2;
  localparam logic [1:0] ST_RES = 2'd3;

endpackage

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational unsigned ALU with carry/borrow output
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = calc_pkg::DIGITS * calc_pkg::DIGIT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] r,
  output logic             c
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - collects operands and op code from the entry sequencer,
// computes the result and selects the value shown on the display
module operand_collector #(
  parameter int DIGITS  = calc_pkg::DIGITS,
  parameter int DIGIT_W = calc_pkg::DIGIT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger_1,
  input  logic                      trigger_2,
  input  logic                      trigger_op,
  input  logic [1:0]                estado,
  input  logic [DIGIT_W-1:0]        sw_digit,
  input  logic [1:0]                sw_op,
  output logic [DIGITS*DIGIT_W-1:0] disp_value,
  output logic [2:0]                digits_a,
  output logic [2:0]                digits_b,
  output logic                      result_vld,
  output logic                      flag_c,
  output logic                      flag_z,
  output logic                      flag_n
);
  import calc_pkg::*;

  localparam int         W    = DIGITS * DIGIT_W;
  localparam logic [2:0] DMAX = 3'(DIGITS);

  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [2:0]   digits_a_q, digits_a_d, digits_b_q, digits_b_d;
  logic [1:0]   estado_q, estado_d;
  op_t          op_reg_q, op_reg_d;
  logic         result_vld_q, result_vld_d;
  logic         flag_c_q, flag_c_d, flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic [W-1:0] alu_r;
  logic         alu_c;
  logic         new_entry, load_res;

  calc_alu #(.WIDTH(W)) u_alu (
    .a  (op_a_q),
    .b  (op_b_q),
    .op (op_reg_q),
    .r  (alu_r),
    .c  (alu_c)
  );

  assign new_entry = (estado == ST_A) && (estado_q == ST_RES);
  assign load_res  = (estado == ST_RES) && (estado_q == ST_OP);

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    digits_a_d   = digits_a_q;
    digits_b_d   = digits_b_q;
    estado_d     = estado;
    op_reg_d     = op_reg_q;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;

    // The clear comes first so a digit strobed in the same cycle lands in the fresh operand.
    if (new_entry) begin
      op_a_d       = '0;
      op_b_d       = '0;
      digits_a_d   = '0;
      digits_b_d   = '0;
      result_vld_d = 1'b0;
      flag_c_d     = 1'b0;
      flag_z_d     = 1'b0;
      flag_n_d     = 1'b0;
    end

    if (trigger_1 && (digits_a_d < DMAX)) begin
      op_a_d     = {op_a_d[W-DIGIT_W-1:0], sw_digit};
      digits_a_d = digits_a_d + 3'd1;
    end
    if (trigger_2 && (digits_b_d < DMAX)) begin
      op_b_d     = {op_b_d[W-DIGIT_W-1:0], sw_digit};
      digits_b_d = digits_b_d + 3'd1;
    end

    if ((estado == ST_OP) && trigger_op) begin
      op_reg_d = op_t'(sw_op);
    end

    if (load_res) begin
      result_d     = alu_r;
      result_vld_d = 1'b1;
      flag_c_d     = alu_c;
      flag_z_d     = (alu_r == '0);
      flag_n_d     = alu_r[W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      digits_a_q   <= '0;
      digits_b_q   <= '0;
      estado_q     <= ST_A;
      op_reg_q     <= OP_ADD;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      digits_a_q   <= digits_a_d;
      digits_b_q   <= digits_b_d;
      estado_q     <= estado_d;
      op_reg_q     <= op_reg_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      flag_c_q     <= flag_c_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
    end
  end

  always_comb begin
    disp_value = '0;
    case (estado)
      ST_A:    disp_value = op_a_q;
      ST_B:    disp_value = op_b_q;
      ST_OP:   disp_value = {{(W-2){1'b0}}, op_reg_q};
      default: disp_value = result_vld_q ? result_q : '0;
    endcase
  end

  assign digits_a   = digits_a_q;
  assign digits_b   = digits_b_q;
  assign result_vld = result_vld_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;

endmodule
